// File: rtl/anti_theft_fsm.sv
// Anti-theft alarm controller: watches ignition and door sensors, chooses the
// timer interval, pulses start_timer, and drives the status LED and siren enable.
module anti_theft_fsm #(
    parameter int BLINK_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic       expired,
    input  logic       one_hz_enable,
    output logic [1:0] interval,
    output logic       start_timer,
    output logic       status,
    output logic       enable_siren
);

    // Interval codes understood by the timer.
    localparam logic [1:0] T_ARM_DELAY       = 2'b00;
    localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
    localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
    localparam logic [1:0] T_ALARM_ON        = 2'b11;

    // Last blink count before the status LED toggles.
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        ARMED          = 3'd0,
        TRIGGERED      = 3'd1,
        SOUND          = 3'd2,
        ALARM_HOLD     = 3'd3,
        DIS_IGN        = 3'd4,
        DIS_WAIT_OPEN  = 3'd5,
        DIS_WAIT_CLOSE = 3'd6,
        ARM_DELAY      = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] interval_q, interval_d;
    logic       start_timer_q, start_timer_d;
    logic       status_q, status_d;
    logic       enable_siren_q, enable_siren_d;
    logic [3:0] blink_cnt_q, blink_cnt_d;

    logic expired_ok;
    logic any_door;

    // Registered state and outputs; reset puts the alarm straight into ARMED.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ARMED;
            interval_q     <= T_ARM_DELAY;
            start_timer_q  <= 1'b0;
            status_q       <= 1'b0;
            enable_siren_q <= 1'b0;
            blink_cnt_q    <= 4'd0;
        end else begin
            state_q        <= state_d;
            interval_q     <= interval_d;
            start_timer_q  <= start_timer_d;
            status_q       <= status_d;
            enable_siren_q <= enable_siren_d;
            blink_cnt_q    <= blink_cnt_d;
        end
    end

    // Next-state, interval selection, timer start, LED and siren decisions.
    always_comb begin
        state_d        = state_q;
        interval_d     = interval_q;
        start_timer_d  = 1'b0;
        status_d       = status_q;
        blink_cnt_d    = blink_cnt_q;
        enable_siren_d = 1'b0;

        // The timer still shows the previous interval's flag while it loads.
        expired_ok = expired & ~start_timer_q;
        any_door   = door_driver | door_pass;

        if (reprogram) begin
            state_d = ARMED;
        end else if (ignition) begin
            state_d = DIS_IGN;
        end else begin
            case (state_q)
                ARMED: begin
                    if (door_driver) begin
                        state_d       = TRIGGERED;
                        interval_d    = T_DRIVER_DELAY;
                        start_timer_d = 1'b1;
                    end else if (door_pass) begin
                        state_d       = TRIGGERED;
                        interval_d    = T_PASSENGER_DELAY;
                        start_timer_d = 1'b1;
                    end
                end
                TRIGGERED: begin
                    if (expired_ok) state_d = SOUND;
                end
                SOUND: begin
                    if (!any_door) begin
                        state_d       = ALARM_HOLD;
                        interval_d    = T_ALARM_ON;
                        start_timer_d = 1'b1;
                    end
                end
                ALARM_HOLD: begin
                    if (any_door)        state_d = SOUND;
                    else if (expired_ok) state_d = ARMED;
                end
                DIS_IGN: begin
                    state_d = DIS_WAIT_OPEN;
                end
                DIS_WAIT_OPEN: begin
                    if (door_driver) state_d = DIS_WAIT_CLOSE;
                end
                DIS_WAIT_CLOSE: begin
                    if (!any_door) begin
                        state_d       = ARM_DELAY;
                        interval_d    = T_ARM_DELAY;
                        start_timer_d = 1'b1;
                    end
                end
                ARM_DELAY: begin
                    if (any_door)        state_d = DIS_WAIT_CLOSE;
                    else if (expired_ok) state_d = ARMED;
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end

        // Blink only while staying in ARMED; any entry into ARMED restarts dark.
        if (state_d == ARMED) begin
            if ((state_q == ARMED) && !reprogram) begin
                if (one_hz_enable) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        status_d    = ~status_q;
                        blink_cnt_d = 4'd0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 4'd1;
                    end
                end
            end else begin
                status_d    = 1'b0;
                blink_cnt_d = 4'd0;
            end
        end else begin
            blink_cnt_d = 4'd0;
            status_d    = (state_d == TRIGGERED) || (state_d == SOUND) ||
                          (state_d == ALARM_HOLD);
        end

        enable_siren_d = (state_d == SOUND) || (state_d == ALARM_HOLD);
    end

    assign interval     = interval_q;
    assign start_timer  = start_timer_q;
    assign status       = status_q;
    assign enable_siren = enable_siren_q;

endmodule
